// File: rtl/demux_1x2_fifo.sv
// demux_1x2_fifo
// De-interleaves a 2:1 round-robin byte stream back into two lanes. A lane
// selector toggles every clock in lock-step with the upstream mux. Each lane
// buffers its bytes in a small FIFO that the consumer drains with a pop
// handshake. A byte pushed into a full lane is dropped and raises a sticky
// overflow flag.
//
// Ports
//   clk                 clock, all logic on posedge
//   reset               asynchronous reset, active-low
//   data_in, valid_in   interleaved byte stream from the mux
//   pop0, pop1          per-lane pop requests
//   data_out0/1         popped byte, registered, 1-cycle pop latency
//   valid_out0/1        1-cycle pulse per successful pop
//   empty0/1, full0/1   registered occupancy flags
//   overflow0/1         sticky: a byte was dropped on a full lane
module demux_1x2_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              pop0,
    input  logic              pop1,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic              empty0,
    output logic              empty1,
    output logic              full0,
    output logic              full1,
    output logic              overflow0,
    output logic              overflow1
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned NLANE = 2;

    logic                r_sel;
    logic [DATA_W-1:0]   r_mem   [NLANE][DEPTH];
    logic [ADDR_W-1:0]   r_wptr  [NLANE];
    logic [ADDR_W-1:0]   r_rptr  [NLANE];
    logic [CNT_W-1:0]    r_count [NLANE];
    logic [DATA_W-1:0]   r_dout  [NLANE];
    logic [NLANE-1:0]    r_vout;
    logic [NLANE-1:0]    r_empty;
    logic [NLANE-1:0]    r_full;
    logic [NLANE-1:0]    r_ovf;

    logic [NLANE-1:0]    w_pop_req;
    logic [NLANE-1:0]    w_push;
    logic [NLANE-1:0]    w_pop;
    logic [NLANE-1:0]    w_accept;
    logic [NLANE-1:0]    w_drop;
    logic [CNT_W-1:0]    w_count_nxt [NLANE];

    // Per-lane push/pop qualification and next occupancy.
    // A pop on a full lane frees the slot that a same-edge push then uses.
    always_comb begin
        w_pop_req   = {pop1, pop0};
        w_push      = '0;
        w_pop       = '0;
        w_accept    = '0;
        w_drop      = '0;
        w_count_nxt = '{default: '0};
        for (int l = 0; l < int'(NLANE); l++) begin
            w_push[l]      = valid_in && (r_sel == 1'(l));
            w_pop[l]       = w_pop_req[l] && (r_count[l] != '0);
            w_accept[l]    = w_push[l] && ((r_count[l] != CNT_W'(DEPTH)) || w_pop[l]);
            w_drop[l]      = w_push[l] && !w_accept[l];
            w_count_nxt[l] = CNT_W'(r_count[l] + CNT_W'(w_accept[l]) - CNT_W'(w_pop[l]));
        end
    end

    // Selector, pointers, counts, flags and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel   <= 1'b0;
            r_vout  <= '0;
            r_empty <= '1;
            r_full  <= '0;
            r_ovf   <= '0;
            for (int l = 0; l < int'(NLANE); l++) begin
                r_wptr[l]  <= '0;
                r_rptr[l]  <= '0;
                r_count[l] <= '0;
                r_dout[l]  <= '0;
            end
        end else begin
            r_sel <= ~r_sel;
            for (int l = 0; l < int'(NLANE); l++) begin
                if (w_accept[l]) begin
                    r_wptr[l] <= ADDR_W'(r_wptr[l] + ADDR_W'(1));
                end
                if (w_pop[l]) begin
                    r_rptr[l] <= ADDR_W'(r_rptr[l] + ADDR_W'(1));
                    r_dout[l] <= r_mem[l][r_rptr[l]];
                end
                r_vout[l]  <= w_pop[l];
                r_count[l] <= w_count_nxt[l];
                r_empty[l] <= (w_count_nxt[l] == '0);
                r_full[l]  <= (w_count_nxt[l] == CNT_W'(DEPTH));
                r_ovf[l]   <= r_ovf[l] | w_drop[l];
            end
        end
    end

    // Storage is deliberately left out of reset; the read of the old head
    // happens before a same-edge write lands, so there is no bypass.
    always_ff @(posedge clk) begin
        for (int l = 0; l < int'(NLANE); l++) begin
            if (w_accept[l]) begin
                r_mem[l][r_wptr[l]] <= data_in;
            end
        end
    end

    assign data_out0  = r_dout[0];
    assign data_out1  = r_dout[1];
    assign valid_out0 = r_vout[0];
    assign valid_out1 = r_vout[1];
    assign empty0     = r_empty[0];
    assign empty1     = r_empty[1];
    assign full0      = r_full[0];
    assign full1      = r_full[1];
    assign overflow0  = r_ovf[0];
    assign overflow1  = r_ovf[1];

endmodule
